// File: rtl/nes_rate_select.sv
// NES-pad rate chooser: debounced buttons select one of N_RATES tick rates; switching happens on tick boundaries.
// Optional `RATE_CYCLE_EN: Start/Select step the selection up/down with wraparound.
module nes_rate_select #(
    parameter int unsigned N_RATES     = 4,
    parameter int unsigned BASE_DIV    = 1000,
    parameter int unsigned DIV_SHIFT   = 1,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned DEB_CYCLES  = 16,
    parameter int unsigned DEFAULT_SEL = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [7:0]                 btn_n,
    input  logic                       hold,
    output logic                       tick,
    output logic [$clog2(N_RATES)-1:0] cur_sel,
    output logic                       pend_valid,
    output logic                       sel_changed
);
    localparam int unsigned SEL_W = $clog2(N_RATES);
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    logic [7:0]             sync1_q, sync1_d;
    logic [7:0]             sync2_q, sync2_d;
    logic [7:0]             deb_q, deb_d;
    logic [7:0][DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [7:0]             press_q, press_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0]       cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]       pend_sel_q, pend_sel_d;
    logic                   pend_valid_q, pend_valid_d;
    logic                   tick_q, tick_d;
    logic                   sel_changed_q, sel_changed_d;

    logic                   req_valid;
    logic [SEL_W-1:0]       req_sel;
    logic [CNT_W-1:0]       divisor;
    logic                   wrap;
`ifdef RATE_CYCLE_EN
    logic [SEL_W-1:0]       step_base;
`endif

    always_comb begin
        sync1_d   = btn_n;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int unsigned i = 0; i < 8; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                deb_d[i]     = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
        end
        press_d = deb_q & ~deb_d;
    end

    // D-pad first (Down > Left > Right > Up); indices beyond N_RATES are filtered out.
    always_comb begin
        req_valid = 1'b0;
        req_sel   = '0;
        if (press_q[5]) begin
            req_valid = 1'b1;
            req_sel   = SEL_W'(0);
        end else if (press_q[6]) begin
            req_valid = 1'b1;
            req_sel   = SEL_W'(1);
        end else if (press_q[7] && N_RATES > 2) begin
            req_valid = 1'b1;
            req_sel   = SEL_W'(2);
        end else if (press_q[4] && N_RATES > 3) begin
            req_valid = 1'b1;
            req_sel   = SEL_W'(3);
        end
`ifdef RATE_CYCLE_EN
        step_base = pend_valid_q ? pend_sel_q : cur_sel_q;
        if (!req_valid && press_q[3]) begin
            req_valid = 1'b1;
            req_sel   = (step_base == SEL_W'(N_RATES - 1)) ? '0 : step_base + SEL_W'(1);
        end else if (!req_valid && press_q[2]) begin
            req_valid = 1'b1;
            req_sel   = (step_base == '0) ? SEL_W'(N_RATES - 1) : step_base - SEL_W'(1);
        end
`endif
    end

    always_comb begin
        divisor       = CNT_W'(BASE_DIV) << (32'(cur_sel_q) * DIV_SHIFT);
        wrap          = !hold && (cnt_q == divisor - CNT_W'(1));
        cnt_d         = cnt_q;
        cur_sel_d     = cur_sel_q;
        pend_sel_d    = pend_sel_q;
        pend_valid_d  = pend_valid_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (wrap && pend_valid_q) begin
            cur_sel_d    = pend_sel_q;
            pend_valid_d = 1'b0;
        end
        // Applied after the switch so a press on the wrap cycle queues for the next boundary.
        if (req_valid && !(req_sel == cur_sel_q && !pend_valid_q)) begin
            pend_valid_d = 1'b1;
            pend_sel_d   = req_sel;
        end
        tick_d        = wrap;
        sel_changed_d = wrap && pend_valid_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            deb_q         <= '1;
            deb_cnt_q     <= '0;
            press_q       <= '0;
            cnt_q         <= '0;
            cur_sel_q     <= SEL_W'(DEFAULT_SEL);
            pend_sel_q    <= '0;
            pend_valid_q  <= 1'b0;
            tick_q        <= 1'b0;
            sel_changed_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_q         <= deb_d;
            deb_cnt_q     <= deb_cnt_d;
            press_q       <= press_d;
            cnt_q         <= cnt_d;
            cur_sel_q     <= cur_sel_d;
            pend_sel_q    <= pend_sel_d;
            pend_valid_q  <= pend_valid_d;
            tick_q        <= tick_d;
            sel_changed_q <= sel_changed_d;
        end
    end

    assign tick        = tick_q;
    assign cur_sel     = cur_sel_q;
    assign pend_valid  = pend_valid_q;
    assign sel_changed = sel_changed_q;
endmodule

// File: tb/tb_nes_rate_select.sv
// Self-checking bench for nes_rate_select with short periods (4/8/16/32) and 3-cycle debounce.
// Define RATE_CYCLE_EN to also exercise Start/Select stepping.
module tb_nes_rate_select;
    localparam int N   = 4;
    localparam int BD  = 4;
    localparam int DS  = 1;
    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] btn_n = 8'hFF;
    logic       hold = 1'b0;
    logic       tick;
    logic [1:0] cur_sel;
    logic       pend_valid;
    logic       sel_changed;

    int n_checks = 0;
    int n_fail   = 0;

    nes_rate_select #(
        .N_RATES(N), .BASE_DIV(BD), .DIV_SHIFT(DS), .CNT_W(24),
        .DEB_CYCLES(DEB), .DEFAULT_SEL(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn_n(btn_n), .hold(hold),
        .tick(tick), .cur_sel(cur_sel), .pend_valid(pend_valid), .sel_changed(sel_changed)
    );

    always #5 clk = ~clk;

    // Reference model: button samples pass a 2-stage pipe, a debounced bit flips once the
    // last DEB synchronised samples all disagree with it; selection/tick rules follow the rate table.
    int m_s1[8], m_s2[8], m_deb[8], m_ev[8];
    int m_hist[8][DEB];
    int m_cnt, m_sel, m_pv, m_ps, m_tick, m_chg;

    function automatic int period(int s);
        return BD << (s * DS);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_s1[i] = 1; m_s2[i] = 1; m_deb[i] = 1; m_ev[i] = 0;
            for (int j = 0; j < DEB; j++) m_hist[i][j] = 1;
        end
        m_cnt = 0; m_sel = 0; m_pv = 0; m_ps = 0; m_tick = 0; m_chg = 0;
    endtask

    task automatic model_edge();
        int dpad[4];
        int req, wrap, n_sel, n_pv, n_ps, n_cnt, all_diff;
`ifdef RATE_CYCLE_EN
        int base;
`endif
        if (!reset_n) begin
            model_reset();
            return;
        end
        dpad = '{5, 6, 7, 4};
        req = -1;
        for (int k = 0; k < 4; k++)
            if (req < 0 && k < N && m_ev[dpad[k]] != 0) req = k;
`ifdef RATE_CYCLE_EN
        base = (m_pv != 0) ? m_ps : m_sel;
        if (req < 0 && m_ev[3] != 0) req = (base + 1) % N;
        else if (req < 0 && m_ev[2] != 0) req = (base + N - 1) % N;
`endif
        wrap  = (!hold && m_cnt == period(m_sel) - 1) ? 1 : 0;
        n_sel = m_sel; n_pv = m_pv; n_ps = m_ps;
        n_cnt = wrap ? 0 : (hold ? m_cnt : m_cnt + 1);
        if (wrap && m_pv) begin n_sel = m_ps; n_pv = 0; end
        if (req >= 0 && !(req == m_sel && m_pv == 0)) begin n_pv = 1; n_ps = req; end
        m_tick = wrap;
        m_chg  = (wrap && m_pv) ? 1 : 0;
        m_sel = n_sel; m_pv = n_pv; m_ps = n_ps; m_cnt = n_cnt;
        for (int i = 0; i < 8; i++) begin
            for (int j = DEB - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
            m_hist[i][0] = m_s2[i];
            all_diff = 1;
            for (int j = 0; j < DEB; j++) if (m_hist[i][j] == m_deb[i]) all_diff = 0;
            m_ev[i] = (all_diff && m_deb[i] == 1) ? 1 : 0;
            if (all_diff) m_deb[i] = 1 - m_deb[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = btn_n[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic press(input int bit_idx, input int cycles);
        btn_n[bit_idx] = 1'b0;
        repeat (cycles) step();
        btn_n[bit_idx] = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        n_checks++;
        if (tick !== 1'b0 || sel_changed !== 1'b0 || pend_valid !== 1'b0 || cur_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got tick=%b chg=%b pend=%b sel=%0d, expected 0/0/0/0",
                     tick, sel_changed, pend_valid, cur_sel);
        end
        reset_n = 1'b1;
        step();
        n_checks++;
        if (tick !== 1'b0 || cur_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: got tick=%b sel=%0d, expected 0/0", tick, cur_sel);
        end
    endtask

    task automatic test_base_rate();
        int ticks = 0, bad = 0, last = -1, bad_gap = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (tick) begin
                if (last >= 0 && c - last != 4) bad_gap++;
                last = c;
                ticks++;
            end
            if (sel_changed !== 1'b0 || cur_sel !== 2'd0) bad++;
        end
        n_checks++;
        if (ticks != 10) begin
            n_fail++;
            $display("FAIL base_tick_count: got %0d expected 10", ticks);
        end
        n_checks++;
        if (bad_gap != 0) begin
            n_fail++;
            $display("FAIL base_tick_gap: got %0d wrong gaps expected 0", bad_gap);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL base_idle: got %0d cycles with switch activity expected 0", bad);
        end
    endtask

    task automatic test_dpad_left();
        int got = 0, gap = 0;
        btn_n[6] = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            step();
            if (sel_changed) got = 1;
        end
        btn_n[6] = 1'b1;
        n_checks++;
        if (!got || cur_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL left_switch: got seen=%0d sel=%0d expected seen=1 sel=1", got, cur_sel);
        end
        do begin
            step();
            gap++;
        end while (!tick && gap < 50);
        n_checks++;
        if (gap != 8) begin
            n_fail++;
            $display("FAIL left_period: got %0d expected 8", gap);
        end
    endtask

    task automatic test_glitch();
        int saw_pend = 0, got = 0;
        press(7, 2);
        for (int c = 0; c < 20; c++) begin
            step();
            if (pend_valid) saw_pend = 1;
        end
        n_checks++;
        if (saw_pend != 0 || cur_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL glitch_reject: got pend_seen=%0d sel=%0d expected 0/1", saw_pend, cur_sel);
        end
        press(7, 4);
        for (int c = 0; c < 100 && !got; c++) begin
            step();
            if (sel_changed) got = 1;
        end
        n_checks++;
        if (!got || cur_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL right_switch: got seen=%0d sel=%0d expected 1/2", got, cur_sel);
        end
    endtask

    task automatic test_priority();
        int got = 0, extra = 0;
        btn_n[5] = 1'b0;
        btn_n[4] = 1'b0;
        repeat (8) step();
        btn_n[5] = 1'b1;
        btn_n[4] = 1'b1;
        for (int c = 0; c < 150 && !got; c++) begin
            step();
            if (sel_changed) got = 1;
        end
        n_checks++;
        if (!got || cur_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL down_priority: got seen=%0d sel=%0d expected 1/0", got, cur_sel);
        end
        for (int c = 0; c < 40; c++) begin
            step();
            if (pend_valid || cur_sel !== 2'd0) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL up_dropped: got %0d cycles of stray activity expected 0", extra);
        end
    endtask

    task automatic test_hold();
        int got = 0, bad = 0;
        hold = 1'b1;
        step();
        press(4, 8);
        for (int c = 0; c < 30 && !got; c++) begin
            step();
            if (pend_valid) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL hold_accept: got pend=%b expected 1", pend_valid);
        end
        for (int c = 0; c < 50; c++) begin
            step();
            if (tick || cur_sel !== 2'd0 || !pend_valid) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_freeze: got %0d bad cycles expected 0", bad);
        end
        hold = 1'b0;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            step();
            if (sel_changed) got = 1;
        end
        n_checks++;
        if (!got || cur_sel !== 2'd3) begin
            n_fail++;
            $display("FAIL hold_release_switch: got seen=%0d sel=%0d expected 1/3", got, cur_sel);
        end
    endtask

    task automatic test_reset_mid_pending();
        int got = 0;
        hold = 1'b1;
        press(6, 6);
        for (int c = 0; c < 30 && !got; c++) begin
            step();
            if (pend_valid) got = 1;
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (!got || pend_valid !== 1'b0 || cur_sel !== 2'd0 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pending: got pend_seen=%0d pend=%b sel=%0d tick=%b expected 1/0/0/0",
                     got, pend_valid, cur_sel, tick);
        end
        hold = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

`ifdef RATE_CYCLE_EN
    task automatic test_rate_cycle();
        int got;
        int bits[3] = '{4, 3, 2};
        int want[3] = '{3, 0, 3};
        for (int t = 0; t < 3; t++) begin
            got = 0;
            press(bits[t], 6);
            for (int c = 0; c < 120 && !got; c++) begin
                step();
                if (sel_changed) got = 1;
            end
            n_checks++;
            if (!got || cur_sel !== 2'(want[t])) begin
                n_fail++;
                $display("FAIL cycle_step%0d: got seen=%0d sel=%0d expected 1/%0d", t, got, cur_sel, want[t]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int err = 0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 11) == 0) btn_n[i] = ~btn_n[i];
            if ($urandom_range(0, 59) == 0) hold = ~hold;
            step();
            n_checks++;
            if (tick !== 1'(m_tick) || cur_sel !== 2'(m_sel) ||
                pend_valid !== 1'(m_pv) || sel_changed !== 1'(m_chg)) begin
                n_fail++;
                if (err < 10)
                    $display("FAIL random_c%0d: got tick=%b sel=%0d pend=%b chg=%b expected %0d/%0d/%0d/%0d",
                             c, tick, cur_sel, pend_valid, sel_changed, m_tick, m_sel, m_pv, m_chg);
                err++;
            end
        end
        hold = 1'b0;
        btn_n = 8'hFF;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_base_rate();
        test_dpad_left();
        test_glitch();
        test_priority();
        test_hold();
        test_reset_mid_pending();
`ifdef RATE_CYCLE_EN
        test_rate_cycle();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
